// File: rtl/bounce_box_src_if.sv
// Pixel-source link between the bouncing-box source and the TMDS encoder.
// The encoder side drives geometry and read/line/frame strobes and takes the pixel back.
interface bounce_box_src_if #(
    parameter int BITS_PER_COLOR = 8
);
    logic [9:0]                  i_width;
    logic [9:0]                  i_height;
    logic                        i_rd;
    logic                        i_newline;
    logic                        i_newframe;
    logic [3*BITS_PER_COLOR-1:0] o_pixel;

    modport master (
        output i_width, i_height, i_rd, i_newline, i_newframe,
        input  o_pixel
    );

    modport slave (
        input  i_width, i_height, i_rd, i_newline, i_newframe,
        output o_pixel
    );
endinterface

// File: rtl/bounce_box_src.sv
// Bouncing-box video source: gradient background plus a solid square that moves
// STEP pixels per frame and reflects off the active-area edges. The pixel output
// is registered from the next-state position, so it always matches the position
// held in the same cycle and back-to-back reads see no bubble.
module bounce_box_src #(
    parameter int                            BITS_PER_COLOR = 8,
    parameter int                            BOX            = 32,
    parameter int                            STEP           = 4,
    parameter logic [3*BITS_PER_COLOR-1:0]   BOX_COLOR      = '1
) (
    input  logic              i_pixclk,
    input  logic              i_reset_n,
    bounce_box_src_if.slave   bus
);
    localparam int BPC = BITS_PER_COLOR;
    localparam int PW  = 3 * BPC;

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] BOX11  = 11'(BOX);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [9:0]  BOX10  = 10'(BOX);

    // Background blue level: a quarter of full scale, zero for one-bit colour.
    function automatic logic [BPC-1:0] bg_blue();
        logic [BPC-1:0] b;
        b = '0;
        if (BPC >= 2) b[(BPC >= 2) ? BPC-2 : 0] = 1'b1;
        return b;
    endfunction
    localparam logic [BPC-1:0] BG_B = bg_blue();

    logic [9:0] x, y, bx, by;
    logic       dx, dy;
    logic [9:0] x_n, y_n, bx_n, by_n;
    logic       dx_n, dy_n;
    logic [PW-1:0] pixel;

    // One axis of box motion; returns {new_dir, new_pos}. 11-bit compare avoids overflow.
    function automatic logic [10:0] move(input logic [9:0] pos, input logic dir,
                                         input logic [9:0] lim);
        logic [9:0] p;
        logic       d;
        p = pos;
        d = dir;
        if (dir) begin
            if ({1'b0, pos} + STEP11 + BOX11 > {1'b0, lim}) begin
                p = lim - BOX10;
                d = 1'b0;
            end else begin
                p = pos + STEP10;
            end
        end else begin
            if (pos < STEP10) begin
                p = '0;
                d = 1'b1;
            end else begin
                p = pos - STEP10;
            end
        end
        return {d, p};
    endfunction

    // Colour for a position given the box corner.
    function automatic logic [PW-1:0] shade(input logic [9:0] px, input logic [9:0] py,
                                            input logic [9:0] qx, input logic [9:0] qy);
        logic in_x, in_y;
        logic [9:0] r, g;
        in_x = ({1'b0, px} >= {1'b0, qx}) && ({1'b0, px} < {1'b0, qx} + BOX11);
        in_y = ({1'b0, py} >= {1'b0, qy}) && ({1'b0, py} < {1'b0, qy} + BOX11);
        r = px >> (10 - BPC);
        g = py >> (10 - BPC);
        if (in_x && in_y) return BOX_COLOR;
        return {r[BPC-1:0], g[BPC-1:0], BG_B};
    endfunction

    // Next position and box state; frame beats line beats read.
    always_comb begin
        x_n  = x;
        y_n  = y;
        bx_n = bx;
        by_n = by;
        dx_n = dx;
        dy_n = dy;
        if (bus.i_newframe) begin
            x_n = '0;
            y_n = '0;
            {dx_n, bx_n} = move(bx, dx, bus.i_width);
            {dy_n, by_n} = move(by, dy, bus.i_height);
        end else if (bus.i_newline) begin
            x_n = '0;
            if (y < bus.i_height - 10'd1) y_n = y + 10'd1;
        end else if (bus.i_rd) begin
            if (x < bus.i_width - 10'd1) x_n = x + 10'd1;
        end
    end

    // Position, box corner, direction and the registered pixel of the new position.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x     <= '0;
            y     <= '0;
            bx    <= '0;
            by    <= '0;
            dx    <= 1'b1;
            dy    <= 1'b1;
            pixel <= BOX_COLOR;
        end else begin
            x     <= x_n;
            y     <= y_n;
            bx    <= bx_n;
            by    <= by_n;
            dx    <= dx_n;
            dy    <= dy_n;
            pixel <= shade(x_n, y_n, bx_n, by_n);
        end
    end

    assign bus.o_pixel = pixel;
endmodule

// File: tb/tb_bounce_box_src.sv
// Bench for bounce_box_src at 640x480, 8 bits/colour, 32-pixel box, step 4.
// A plain-integer model tracks position and box from the strobe rules; a
// negedge process compares every cycle, and literal checks pin known points.
module tb_bounce_box_src;
    localparam int BPC  = 8;
    localparam int BOX  = 32;
    localparam int STEP = 4;
    localparam int W    = 640;
    localparam int H    = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    bounce_box_src_if #(.BITS_PER_COLOR(BPC)) bus();

    bounce_box_src #(
        .BITS_PER_COLOR(BPC), .BOX(BOX), .STEP(STEP), .BOX_COLOR(24'hFFFFFF)
    ) dut (
        .i_pixclk(clk),
        .i_reset_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state as plain integers.
    int mx, my, mbx, mby, mdx, mdy;

    function automatic int exp_pix(int px, int py, int qx, int qy);
        if (px >= qx && px < qx + BOX && py >= qy && py < qy + BOX) return 32'hFFFFFF;
        return ((px / 4) << 16) | ((py / 4) << 8) | 32'h40;
    endfunction

    task automatic bounce(inout int p, inout int d, input int lim);
        if (d == 1) begin
            if (p + STEP + BOX > lim) begin p = lim - BOX; d = 0; end
            else p = p + STEP;
        end else begin
            if (p < STEP) begin p = 0; d = 1; end
            else p = p - STEP;
        end
    endtask

    // Model update from the strobes seen at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx = 0; my = 0; mbx = 0; mby = 0; mdx = 1; mdy = 1;
        end else if (bus.i_newframe) begin
            mx = 0; my = 0;
            bounce(mbx, mdx, W);
            bounce(mby, mdy, H);
        end else if (bus.i_newline) begin
            mx = 0;
            if (my < H - 1) my = my + 1;
        end else if (bus.i_rd) begin
            if (mx < W - 1) mx = mx + 1;
        end
    end

    // Every-cycle comparison of the DUT pixel with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (int'(bus.o_pixel) != exp_pix(mx, my, mbx, mby)) begin
                n_err++;
                $display("FAIL pixel_cycle t=%0t got=%06h exp=%06h x=%0d y=%0d bx=%0d by=%0d",
                         $time, bus.o_pixel, exp_pix(mx, my, mbx, mby), mx, my, mbx, mby);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_chk++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic cyc(input bit rd, input bit nl, input bit nf);
        bus.i_rd = rd;
        bus.i_newline = nl;
        bus.i_newframe = nf;
        @(posedge clk);
        #1;
        bus.i_rd = 1'b0;
        bus.i_newline = 1'b0;
        bus.i_newframe = 1'b0;
    endtask

    // Walk down to the box and across it so its edges pass the compare process.
    task automatic scan_box();
        int ty, tx;
        ty = mby + 1;
        tx = mbx + BOX + 2;
        repeat (ty) cyc(0, 1, 0);
        repeat (tx) cyc(1, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset_pix", int'(bus.o_pixel), 32'hFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0);
        chk("post_release_pix", int'(bus.o_pixel), 32'hFFFFFF);
    endtask

    initial begin
        int r;
        bus.i_width = 10'(W);
        bus.i_height = 10'(H);
        bus.i_rd = 1'b0;
        bus.i_newline = 1'b0;
        bus.i_newframe = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        chk_en = 1'b1;
        chk("reset_pix", int'(bus.o_pixel), 32'hFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0);

        // Line 0 reads through and past the box.
        for (int k = 1; k <= 40; k++) begin
            cyc(1, 0, 0);
            if (k == 31) chk("x31_box", int'(bus.o_pixel), 32'hFFFFFF);
            if (k == 32) chk("x32_bg", int'(bus.o_pixel), 32'h080040);
            if (k == 36) chk("x36_bg", int'(bus.o_pixel), 32'h090040);
        end

        // Down to line 40.
        repeat (40) cyc(0, 1, 0);
        chk("line40_x0", int'(bus.o_pixel), 32'h000A40);
        cyc(1, 0, 0);
        chk("line40_x1", int'(bus.o_pixel), 32'h000A40);

        // First frame step.
        cyc(0, 0, 1);
        chk("frame1_bx", mbx, 4);
        chk("frame1_by", mby, 4);
        chk("frame1_l0x0", int'(bus.o_pixel), 32'h000040);
        repeat (4) cyc(0, 1, 0);
        repeat (3) cyc(1, 0, 0);
        chk("l4_x3", int'(bus.o_pixel), 32'h000140);
        cyc(1, 0, 0);
        chk("l4_x4_box", int'(bus.o_pixel), 32'hFFFFFF);

        // Many frames: both bounces, left clamp, with periodic box scans.
        for (int f = 2; f <= 330; f++) begin
            cyc(0, 0, 1);
            if (f == 112) chk("f112_by", mby, 448);
            if (f == 113) begin chk("f113_by", mby, 448); chk("f113_dy", mdy, 0); end
            if (f == 114) chk("f114_by", mby, 444);
            if (f == 152) chk("f152_bx", mbx, 608);
            if (f == 153) begin chk("f153_bx", mbx, 608); chk("f153_dx", mdx, 0); end
            if (f == 154) chk("f154_bx", mbx, 604);
            if (f == 305) begin chk("f305_bx", mbx, 0); chk("f305_dx", mdx, 0); end
            if (f == 306) begin chk("f306_bx", mbx, 0); chk("f306_dx", mdx, 1); end
            if (f == 307) chk("f307_bx", mbx, 4);
            if (f % 20 == 0 || f == 153 || f == 306) scan_box();
        end

        // Simultaneous strobes.
        repeat (10) cyc(0, 1, 0);
        repeat (10) cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("combo3_x", mx, 0);
        chk("combo3_y", my, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("combo2_x", mx, 0);
        chk("combo2_y", my, 4);

        // Random strobes.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
            else if (r < 25) cyc($urandom_range(0, 1) == 1, 1, 0);
            else if (r < 725) cyc(1, 0, 0);
            else cyc(0, 0, 0);
        end

        // Saturation of x and y, then asynchronous reset mid-frame.
        do_reset();
        cyc(0, 0, 1);
        repeat (700) cyc(1, 0, 0);
        chk("x_sat_pix", int'(bus.o_pixel), 32'h9F0040);
        chk("x_sat_x", mx, 639);
        repeat (490) cyc(0, 1, 0);
        chk("y_sat_pix", int'(bus.o_pixel), 32'h007740);
        cyc(0, 0, 1);
        repeat (200) cyc(0, 1, 0);
        repeat (300) cyc(1, 0, 0);
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            cyc(1, 0, 0);
            if (k == 31) chk("rst_x31_box", int'(bus.o_pixel), 32'hFFFFFF);
            if (k == 32) chk("rst_x32_bg", int'(bus.o_pixel), 32'h080040);
        end

        chk_en = 1'b0;
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
